// File: rtl/airlock_sequencer.sv
// airlock_sequencer
// Runs the airlock chamber sequence for latched arrive/depart requests:
// evacuate/pressurize timing, outer/inner door opening and completion pulses.
// Moore machine; every output is decoded from registered state.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   tick             one-cycle timing enable; timers advance only when high
//   arrive_req       level request: craft outside wants in
//   depart_req       level request: craft inside wants out
//   door_obstructed  level; holds an open door open
//   outer_open       outer door open command
//   inner_open       inner door open command
//   pump_out         evacuation pump on
//   pump_in          pressurization valve on
//   pressurized      idle at station pressure, doors closed
//   evacuated        idle at vacuum, doors closed
//   busy             high in every non-idle state
//   arrive_done      one-cycle pulse when an arrival completes
//   depart_done      one-cycle pulse when a departure completes
//
// state   | meaning
// IDLE_P  | idle, chamber pressurized
// IDLE_E  | idle, chamber evacuated
// A_EVAC  | arrival: pumping chamber down
// A_OUTER | arrival: outer door open, craft enters
// A_PRESS | arrival: pressurizing chamber
// A_INNER | arrival: inner door open, craft moves inside
// D_PRESS | departure: pressurizing chamber before inner door
// D_INNER | departure: inner door open, craft enters chamber
// D_EVAC  | departure: pumping chamber down
// D_OUTER | departure: outer door open, craft leaves

module airlock_sequencer #(
  parameter int unsigned EVAC_TICKS  = 8,
  parameter int unsigned PRESS_TICKS = 7,
  parameter int unsigned DOOR_TICKS  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic arrive_req,
  input  logic depart_req,
  input  logic door_obstructed,
  output logic outer_open,
  output logic inner_open,
  output logic pump_out,
  output logic pump_in,
  output logic pressurized,
  output logic evacuated,
  output logic busy,
  output logic arrive_done,
  output logic depart_done
);

  localparam int unsigned MAX_EP = (EVAC_TICKS > PRESS_TICKS) ? EVAC_TICKS : PRESS_TICKS;
  localparam int unsigned MAX_T  = (MAX_EP > DOOR_TICKS) ? MAX_EP : DOOR_TICKS;
  localparam int unsigned TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [3:0] {
    IDLE_P, IDLE_E,
    A_EVAC, A_OUTER, A_PRESS, A_INNER,
    D_PRESS, D_INNER, D_EVAC, D_OUTER
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            arrive_done_q, arrive_done_d;
  logic            depart_done_q, depart_done_d;

  logic [TW-1:0]   last_cnt;
  logic            is_door;
  logic            hold;
  logic            timer_done;
  logic            req_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE_P;
      timer_q       <= '0;
      arrive_done_q <= 1'b0;
      depart_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      arrive_done_q <= arrive_done_d;
      depart_done_q <= depart_done_d;
    end
  end

  // Terminal count and door flag of the current timed state.
  always_comb begin
    last_cnt = '0;
    is_door  = 1'b0;
    unique case (state_q)
      A_EVAC, D_EVAC:                    last_cnt = TW'(EVAC_TICKS - 1);
      A_PRESS, D_PRESS:                  last_cnt = TW'(PRESS_TICKS - 1);
      A_OUTER, A_INNER, D_OUTER, D_INNER: begin
        last_cnt = TW'(DOOR_TICKS - 1);
        is_door  = 1'b1;
      end
      default: last_cnt = '0;
    endcase
  end

  // An obstructed door restarts its full open time once it clears.
  assign hold       = is_door & door_obstructed;
  assign timer_done = tick & (timer_q == last_cnt) & ~hold;
  // The done-pulse cycle is idle but does not accept a new request, so a
  // level held across completion starts the next sequence one cycle later.
  assign req_block  = arrive_done_q | depart_done_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = tick ? timer_q + 1'b1 : timer_q;
    arrive_done_d = 1'b0;
    depart_done_d = 1'b0;

    unique case (state_q)
      IDLE_P: begin
        timer_d = '0;
        if (!req_block) begin
          if (depart_req)      state_d = D_INNER;
          else if (arrive_req) state_d = A_EVAC;
        end
      end
      IDLE_E: begin
        timer_d = '0;
        if (!req_block) begin
          if (arrive_req)      state_d = A_OUTER;
          else if (depart_req) state_d = D_PRESS;
        end
      end
      A_EVAC:  if (timer_done) state_d = A_OUTER;
      A_OUTER: if (timer_done) state_d = A_PRESS;
      A_PRESS: if (timer_done) state_d = A_INNER;
      A_INNER: if (timer_done) begin
        state_d       = IDLE_P;
        arrive_done_d = 1'b1;
      end
      D_PRESS: if (timer_done) state_d = D_INNER;
      D_INNER: if (timer_done) state_d = D_EVAC;
      D_EVAC:  if (timer_done) state_d = D_OUTER;
      D_OUTER: if (timer_done) begin
        state_d       = IDLE_E;
        depart_done_d = 1'b1;
      end
      default: state_d = IDLE_P;
    endcase

    if (hold)               timer_d = '0;
    if (state_d != state_q) timer_d = '0;
  end

  assign outer_open  = (state_q == A_OUTER) || (state_q == D_OUTER);
  assign inner_open  = (state_q == A_INNER) || (state_q == D_INNER);
  assign pump_out    = (state_q == A_EVAC)  || (state_q == D_EVAC);
  assign pump_in     = (state_q == A_PRESS) || (state_q == D_PRESS);
  assign pressurized = (state_q == IDLE_P);
  assign evacuated   = (state_q == IDLE_E);
  assign busy        = (state_q != IDLE_P) && (state_q != IDLE_E);
  assign arrive_done = arrive_done_q;
  assign depart_done = depart_done_q;

endmodule
